pe_issue_queue: RTL and testbench

//  Upstream feeder for the PE core: buffers host operations {opcode_func, op1, op2, op3} in a FIFO.

---
 rtl/pe_issue_queue.sv | 87 ++++++++
 tb/tb_pe_issue_queue.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pe_issue_queue.sv
// pe_issue_queue: FIFO of host ops issued one at a time to the PE, returning each result or a timeout pulse.
module pe_issue_queue #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_opcode_func,
  input  logic [DATA_W-1:0]          in_op1,
  input  logic [DATA_W-1:0]          in_op2,
  input  logic [DATA_W-1:0]          in_op3,
  output logic [DATA_W-1:0]          pe_opcode_func,
  output logic [DATA_W-1:0]          pe_op1,
  output logic [DATA_W-1:0]          pe_op2,
  output logic [DATA_W-1:0]          pe_op3,
  output logic                       pe_valid_in,
  input  logic [DATA_W-1:0]          pe_result_out,
  input  logic                       pe_result_valid,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_result,
  output logic                       out_timeout,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state_q, state_d;
  logic [4*DATA_W-1:0] mem_q [DEPTH];
  logic [4*DATA_W-1:0] pe_word_q, pe_word_d;
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [DATA_W-1:0] out_result_q, out_result_d;
  logic pe_valid_q, out_valid_q, out_timeout_q;
  logic push, pop, done_res, done_to;
  assign in_ready = count_q != CW'(DEPTH);
  assign push = in_valid && in_ready;
  assign pop = state_q == IDLE && count_q != '0;
  assign done_res = state_q == WAIT && pe_result_valid;
  // a result on the final timer edge takes priority over the timeout
  assign done_to = state_q == WAIT && !pe_result_valid && timer_q == TW'(TIMEOUT - 1);
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= {in_opcode_func, in_op1, in_op2, in_op3};
  always_ff @(posedge clk)
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = pop ? WAIT : (done_res || done_to) ? IDLE : state_q;
  always_comb begin
    count_d = count_q + CW'(push) - CW'(pop);
    timer_d = (state_q == WAIT && !done_res && !done_to) ? timer_q + TW'(1) : '0;
    pe_word_d = pop ? mem_q[rd_q] : pe_word_q;
    out_result_d = done_res ? pe_result_out : out_result_q;
  end
  always_ff @(posedge clk)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
      timer_q <= '0;
      pe_word_q <= '0;
      out_result_q <= '0;
      pe_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_timeout_q <= 1'b0;
    end else begin
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      count_q <= count_d;
      timer_q <= timer_d;
      pe_word_q <= pe_word_d;
      out_result_q <= out_result_d;
      pe_valid_q <= pop;
      out_valid_q <= done_res;
      out_timeout_q <= done_to;
    end
  assign {pe_opcode_func, pe_op1, pe_op2, pe_op3} = pe_word_q;
  assign pe_valid_in = pe_valid_q;
  assign out_valid = out_valid_q;
  assign out_result = out_result_q;
  assign out_timeout = out_timeout_q;
  assign count = count_q;
endmodule

// File: tb/tb_pe_issue_queue.sv
// tb_pe_issue_queue: directed scenario bench for pe_issue_queue with hand-computed expectations.
module tb_pe_issue_queue;
  logic clk, rst, in_valid, in_ready, pe_valid_in, pe_result_valid, out_valid, out_timeout;
  logic [31:0] in_opcode_func, in_op1, in_op2, in_op3;
  logic [31:0] pe_opcode_func, pe_op1, pe_op2, pe_op3, pe_result_out, out_result;
  logic [2:0] count;
  int checks = 0;
  int errors = 0;
  pe_issue_queue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode_func(in_opcode_func), .in_op1(in_op1), .in_op2(in_op2), .in_op3(in_op3),
    .pe_opcode_func(pe_opcode_func), .pe_op1(pe_op1), .pe_op2(pe_op2), .pe_op3(pe_op3),
    .pe_valid_in(pe_valid_in), .pe_result_out(pe_result_out), .pe_result_valid(pe_result_valid),
    .out_valid(out_valid), .out_result(out_result), .out_timeout(out_timeout), .count(count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_op(input logic [31:0] opc, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    in_opcode_func = opc;
    in_op1 = a;
    in_op2 = b;
    in_op3 = c;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    pe_result_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    pe_result_valid = 1'b0;
    pe_result_out = '0;
    set_op('0, '0, '0, '0);
    repeat (3) step();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (pe_valid_in !== 1'b0) begin errors++; $display("FAIL reset_pe_valid got %0b exp 0", pe_valid_in); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (out_timeout !== 1'b0) begin errors++; $display("FAIL reset_out_timeout got %0b exp 0", out_timeout); end
    checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL reset_out_result got %0h exp 0", out_result); end
  endtask
  task automatic test_single_op();
    set_op(32'h21, 32'd10, 32'd20, 32'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count_push got %0d exp 1", count); end
    checks++; if (pe_valid_in !== 1'b0) begin errors++; $display("FAIL single_early_issue got %0b exp 0", pe_valid_in); end
    step();
    checks++; if (pe_valid_in !== 1'b1) begin errors++; $display("FAIL single_issue got %0b exp 1", pe_valid_in); end
    checks++; if ({pe_opcode_func, pe_op1, pe_op2, pe_op3} !== {32'h21, 32'd10, 32'd20, 32'd0}) begin errors++; $display("FAIL single_pe_ops got %0h/%0d/%0d/%0d exp 21/10/20/0", pe_opcode_func, pe_op1, pe_op2, pe_op3); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL single_count_pop got %0d exp 0", count); end
    step();
    checks++; if (pe_valid_in !== 1'b0) begin errors++; $display("FAIL single_issue_width got %0b exp 0", pe_valid_in); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early_out got %0b exp 0", out_valid); end
    pe_result_out = 32'd30;
    pe_result_valid = 1'b1;
    step();
    pe_result_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_out_valid got %0b exp 1", out_valid); end
    checks++; if (out_result !== 32'd30) begin errors++; $display("FAIL single_out_result got %0d exp 30", out_result); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_out_width got %0b exp 0", out_valid); end
    checks++; if (out_result !== 32'd30) begin errors++; $display("FAIL single_result_hold got %0d exp 30", out_result); end
  endtask
  task automatic test_timeout_full();
    do_reset();
    in_valid = 1'b1;
    set_op(32'h1, 32'd101, 32'd0, 32'd0);
    step();
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL full_count1 got %0d exp 1", count); end
    set_op(32'h1, 32'd102, 32'd0, 32'd0);
    step();
    checks++; if (pe_valid_in !== 1'b1 || pe_op1 !== 32'd101) begin errors++; $display("FAIL full_issue1 got %0b/%0d exp 1/101", pe_valid_in, pe_op1); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL full_push_pop_count got %0d exp 1", count); end
    for (int k = 3; k <= 5; k++) begin
      set_op(32'h1, 32'(100 + k), 32'd0, 32'd0);
      step();
      checks++; if (count !== 3'(k - 1)) begin errors++; $display("FAIL full_count_k%0d got %0d exp %0d", k, count, k - 1); end
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got %0b exp 0", in_ready); end
    set_op(32'h1, 32'd106, 32'd0, 32'd0);
    for (int i = 6; i <= 17; i++) begin
      step();
      checks++; if (out_timeout !== 1'b0 || count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL full_stall_e%0d got to=%0b cnt=%0d rdy=%0b exp 0/4/0", i, out_timeout, count, in_ready); end
    end
    step();
    checks++; if (out_timeout !== 1'b1) begin errors++; $display("FAIL full_timeout got %0b exp 1", out_timeout); end
    checks++; if (out_valid !== 1'b0 || pe_valid_in !== 1'b0) begin errors++; $display("FAIL full_timeout_side got %0b/%0b exp 0/0", out_valid, pe_valid_in); end
    step();
    checks++; if (pe_valid_in !== 1'b1 || pe_op1 !== 32'd102) begin errors++; $display("FAIL full_issue2 got %0b/%0d exp 1/102", pe_valid_in, pe_op1); end
    checks++; if (out_timeout !== 1'b0 || count !== 3'd3) begin errors++; $display("FAIL full_after_to got %0b/%0d exp 0/3", out_timeout, count); end
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_sixth_push got %0d exp 4", count); end
  endtask
  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1;
    set_op(32'h5, 32'd1, 32'd11, 32'd111);
    step();
    set_op(32'h7, 32'd2, 32'd22, 32'd222);
    step();
    in_valid = 1'b0;
    checks++; if (pe_valid_in !== 1'b1 || pe_op1 !== 32'd1) begin errors++; $display("FAIL b2b_issueA got %0b/%0d exp 1/1", pe_valid_in, pe_op1); end
    step();
    checks++; if (pe_valid_in !== 1'b0 || {pe_opcode_func, pe_op1, pe_op2, pe_op3} !== {32'h5, 32'd1, 32'd11, 32'd111}) begin errors++; $display("FAIL b2b_stableA got %0b/%0h/%0d/%0d/%0d exp 0/5/1/11/111", pe_valid_in, pe_opcode_func, pe_op1, pe_op2, pe_op3); end
    pe_result_out = 32'd5;
    pe_result_valid = 1'b1;
    step();
    pe_result_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd5) begin errors++; $display("FAIL b2b_resA got %0b/%0d exp 1/5", out_valid, out_result); end
    checks++; if (pe_op1 !== 32'd1 || pe_valid_in !== 1'b0) begin errors++; $display("FAIL b2b_holdA got %0d/%0b exp 1/0", pe_op1, pe_valid_in); end
    step();
    checks++; if (pe_valid_in !== 1'b1 || pe_op1 !== 32'd2 || pe_op3 !== 32'd222) begin errors++; $display("FAIL b2b_issueB got %0b/%0d/%0d exp 1/2/222", pe_valid_in, pe_op1, pe_op3); end
    step();
    checks++; if (pe_op2 !== 32'd22 || pe_opcode_func !== 32'h7) begin errors++; $display("FAIL b2b_stableB got %0d/%0h exp 22/7", pe_op2, pe_opcode_func); end
    pe_result_out = 32'd7;
    pe_result_valid = 1'b1;
    step();
    pe_result_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_result !== 32'd7) begin errors++; $display("FAIL b2b_resB got %0b/%0d exp 1/7", out_valid, out_result); end
    step();
    checks++; if (out_valid !== 1'b0 || pe_valid_in !== 1'b0) begin errors++; $display("FAIL b2b_idle got %0b/%0b exp 0/0", out_valid, pe_valid_in); end
  endtask
  task automatic test_idle_and_edge();
    do_reset();
    pe_result_out = 32'd99;
    pe_result_valid = 1'b1;
    step();
    step();
    pe_result_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_result !== 32'd0) begin errors++; $display("FAIL idle_ignore got %0b/%0d exp 0/0", out_valid, out_result); end
    set_op(32'h3, 32'd9, 32'd8, 32'd7);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    checks++; if (pe_valid_in !== 1'b1) begin errors++; $display("FAIL edge_issue got %0b exp 1", pe_valid_in); end
    for (int i = 1; i <= 15; i++) begin
      step();
      checks++; if (out_timeout !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL edge_wait_c%0d got %0b/%0b exp 0/0", i, out_timeout, out_valid); end
    end
    pe_result_out = 32'd55;
    pe_result_valid = 1'b1;
    step();
    pe_result_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_timeout !== 1'b0 || out_result !== 32'd55) begin errors++; $display("FAIL edge_result got %0b/%0b/%0d exp 1/0/55", out_valid, out_timeout, out_result); end
    step();
    checks++; if (out_timeout !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL edge_after got %0b/%0b exp 0/0", out_timeout, out_valid); end
  endtask
  task automatic test_reset_mid_wait();
    do_reset();
    in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      set_op(32'h9, 32'(200 + k), 32'd0, 32'd0);
      step();
    end
    in_valid = 1'b0;
    step();
    checks++; if (count !== 3'd2 || pe_op1 !== 32'd201) begin errors++; $display("FAIL midrst_pre got %0d/%0d exp 2/201", count, pe_op1); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++; if (count !== 3'd0 || in_ready !== 1'b1 || pe_valid_in !== 1'b0 || pe_op1 !== 32'd0) begin errors++; $display("FAIL midrst_state got %0d/%0b/%0b/%0d exp 0/1/0/0", count, in_ready, pe_valid_in, pe_op1); end
    pe_result_out = 32'd77;
    pe_result_valid = 1'b1;
    step();
    pe_result_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_result !== 32'd0) begin errors++; $display("FAIL midrst_late got %0b/%0d exp 0/0", out_valid, out_result); end
    repeat (3) step();
    checks++; if (pe_valid_in !== 1'b0 || count !== 3'd0 || out_timeout !== 1'b0) begin errors++; $display("FAIL midrst_idle got %0b/%0d/%0b exp 0/0/0", pe_valid_in, count, out_timeout); end
  endtask
  initial begin
    test_reset();
    test_single_op();
    test_timeout_full();
    test_back_to_back();
    test_idle_and_edge();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
